rd_addr_gen: RTL and testbench

- Scratchpad read-address generator and window sequencer for the convolution PE datapath.
- Responder to the PE design controller. It starts a row on start_rd_gen, walks filter taps and input-feature (IF) addresses, and waits for clear_regs between windows.
- Returns the status the controller consumes: psum_done, stride_count_flag, stride_pos_ld, full_done.
- Sits between the controller and the IF/filter scratchpads plus the MAC.

---
 rtl/rd_addr_gen.sv | 162 ++++++++++++++++
 tb/tb_rd_addr_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_addr_gen.sv
// Scratchpad read-address generator for the convolution PE datapath.
// Walks filter taps over sliding IF windows and reports window/row status to the controller.
module rd_addr_gen #(
   parameter int FILT_ADDR_LEN = 4,
   parameter int IF_ADDR_LEN   = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     reset_all,
   input  logic                     start_rd_gen,
   input  logic                     usage_stride_pos_ld,
   input  logic                     reset_Filter,
   input  logic                     clear_regs,
   input  logic [FILT_ADDR_LEN-1:0] filt_len,
   input  logic [IF_ADDR_LEN:0]     if_len,
   input  logic [IF_ADDR_LEN-1:0]   stride,
   input  logic [IF_ADDR_LEN:0]     if_avail,
   input  logic                     if_last,
   input  logic                     psum_ready,
   output logic [FILT_ADDR_LEN-1:0] filt_rd_addr,
   output logic [IF_ADDR_LEN-1:0]   if_rd_addr,
   output logic                     rd_en,
   output logic                     mac_valid,
   output logic                     psum_done,
   output logic                     stride_count_flag,
   output logic                     stride_pos_ld,
   output logic                     full_done
);

   localparam int SW = IF_ADDR_LEN + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAIT_CLR} state_t;

   state_t                   r_state, w_nState;
   logic [IF_ADDR_LEN-1:0]   r_wb, w_nWb;
   logic [IF_ADDR_LEN-1:0]   r_sp, w_nSp;
   logic [FILT_ADDR_LEN-1:0] r_k, w_nK;
   logic                     r_macValid;
   logic                     r_psumDone, r_strideCnt, r_stridePos, r_fullDone;
   logic                     w_psumDone, w_strideCnt, w_stridePos, w_fullDone;
   logic [IF_ADDR_LEN:0]     w_rdIdx;
   logic [IF_ADDR_LEN:0]     w_nb;
   logic                     w_read, w_lastTap, w_rowEnd, w_degenerate, w_advance;

   assign w_rdIdx      = {1'b0, r_wb} + (IF_ADDR_LEN+1)'(r_k);
   assign w_nb         = {1'b0, r_wb} + {1'b0, stride};
   assign w_rowEnd     = (SW'(w_nb) + SW'(filt_len)) > SW'(if_len);
   assign w_degenerate = SW'(filt_len) > SW'(if_len);
   assign w_lastTap    = (r_k == (filt_len - FILT_ADDR_LEN'(1)));

   // A soft clear or filter abort suppresses the strobe in the cycle it arrives.
   assign w_read    = (r_state == RUN) && !reset_all && !reset_Filter &&
                      psum_ready && (w_rdIdx < if_avail);
   assign w_advance = ((r_state == DRAIN) || (r_state == WAIT_CLR)) &&
                      clear_regs && !reset_Filter;

   assign rd_en             = w_read;
   assign filt_rd_addr      = w_read ? r_k : '0;
   assign if_rd_addr        = w_read ? w_rdIdx[IF_ADDR_LEN-1:0] : '0;
   assign mac_valid         = r_macValid;
   assign psum_done         = r_psumDone;
   assign stride_count_flag = r_strideCnt;
   assign stride_pos_ld     = r_stridePos;
   assign full_done         = r_fullDone;

   always_comb begin
      w_nState    = r_state;
      w_nWb       = r_wb;
      w_nK        = r_k;
      w_nSp       = r_sp;
      w_psumDone  = 1'b0;
      w_strideCnt = 1'b0;
      w_stridePos = 1'b0;
      w_fullDone  = 1'b0;

      case (r_state)
         IDLE: begin
            if (start_rd_gen) begin
               if (w_degenerate) begin
                  w_stridePos = 1'b1;
                  w_fullDone  = if_last;
               end else begin
                  w_nState = RUN;
                  w_nWb    = usage_stride_pos_ld ? r_sp : '0;
                  w_nK     = '0;
               end
            end
         end
         RUN: begin
            if (w_read) begin
               if (w_lastTap) begin
                  w_nState   = DRAIN;
                  w_nK       = '0;
                  w_psumDone = 1'b1;
               end else begin
                  w_nK = r_k + FILT_ADDR_LEN'(1);
               end
            end
         end
         DRAIN: begin
            if (!clear_regs) w_nState = WAIT_CLR;
         end
         default: ;
      endcase

      // The saved stride position tracks the next base whether or not the row ends.
      if (w_advance) begin
         w_nSp = w_nb[IF_ADDR_LEN-1:0];
         w_nK  = '0;
         if (w_rowEnd) begin
            w_nState    = IDLE;
            w_stridePos = 1'b1;
            w_fullDone  = if_last;
         end else begin
            w_nState    = RUN;
            w_nWb       = w_nb[IF_ADDR_LEN-1:0];
            w_strideCnt = 1'b1;
         end
      end

      if ((r_state != IDLE) && reset_Filter) begin
         w_nState = RUN;
         w_nK     = '0;
      end

      if (reset_all) begin
         w_nState    = IDLE;
         w_nWb       = '0;
         w_nK        = '0;
         w_nSp       = '0;
         w_psumDone  = 1'b0;
         w_strideCnt = 1'b0;
         w_stridePos = 1'b0;
         w_fullDone  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_wb        <= '0;
         r_k         <= '0;
         r_sp        <= '0;
         r_macValid  <= 1'b0;
         r_psumDone  <= 1'b0;
         r_strideCnt <= 1'b0;
         r_stridePos <= 1'b0;
         r_fullDone  <= 1'b0;
      end else begin
         r_state     <= w_nState;
         r_wb        <= w_nWb;
         r_k         <= w_nK;
         r_sp        <= w_nSp;
         r_macValid  <= w_read;
         r_psumDone  <= w_psumDone;
         r_strideCnt <= w_strideCnt;
         r_stridePos <= w_stridePos;
         r_fullDone  <= w_fullDone;
      end
   end

endmodule

// File: tb/tb_rd_addr_gen.sv
// Directed self-checking bench for rd_addr_gen: basic rows, starvation, late clear,
// resume, aborts, resets and the degenerate row.
module tb_rd_addr_gen;

   localparam int FL = 4;
   localparam int IL = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          reset_all;
   logic          start_rd_gen;
   logic          usage_stride_pos_ld;
   logic          reset_Filter;
   logic          clear_regs;
   logic [FL-1:0] filt_len;
   logic [IL:0]   if_len;
   logic [IL-1:0] stride;
   logic [IL:0]   if_avail;
   logic          if_last;
   logic          psum_ready;
   logic [FL-1:0] filt_rd_addr;
   logic [IL-1:0] if_rd_addr;
   logic          rd_en, mac_valid, psum_done, stride_count_flag, stride_pos_ld, full_done;

   logic tieClr;
   logic clrManual;

   int passCnt = 0;
   int totalCnt = 0;

   int gotIf[$];
   int gotFilt[$];
   int psumCnt, scfCnt, splCnt, fullCnt, macCnt;
   int sRd, sIf, sFilt, sPsum, sSpl;
   int splAfter, stallRd;

   int basicIf[$];
   int basicFilt[$];
   int abortIf[$];
   int abortFilt[$];
   int resumeIf[$];
   int resumeFilt[$];

   always #5 clk = ~clk;

   assign clear_regs = tieClr ? psum_done : clrManual;

   rd_addr_gen #(.FILT_ADDR_LEN(FL), .IF_ADDR_LEN(IL)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .reset_all           (reset_all),
      .start_rd_gen        (start_rd_gen),
      .usage_stride_pos_ld (usage_stride_pos_ld),
      .reset_Filter        (reset_Filter),
      .clear_regs          (clear_regs),
      .filt_len            (filt_len),
      .if_len              (if_len),
      .stride              (stride),
      .if_avail            (if_avail),
      .if_last             (if_last),
      .psum_ready          (psum_ready),
      .filt_rd_addr        (filt_rd_addr),
      .if_rd_addr          (if_rd_addr),
      .rd_en               (rd_en),
      .mac_valid           (mac_valid),
      .psum_done           (psum_done),
      .stride_count_flag   (stride_count_flag),
      .stride_pos_ld       (stride_pos_ld),
      .full_done           (full_done)
   );

   task automatic checkOutput(input string tag, input int obs, input int expv);
      totalCnt++;
      if (obs == expv) passCnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
   endtask

   function automatic int outVec();
      return int'({rd_en, mac_valid, psum_done, stride_count_flag, stride_pos_ld,
                   full_done, filt_rd_addr, if_rd_addr});
   endfunction

   task automatic clearMon();
      gotIf.delete();
      gotFilt.delete();
      psumCnt = 0; scfCnt = 0; splCnt = 0; fullCnt = 0; macCnt = 0;
   endtask

   // Sample on the falling edge, then return just after the next rising edge to drive.
   task automatic stepCycle();
      @(negedge clk);
      sRd   = int'(rd_en);
      sIf   = int'(if_rd_addr);
      sFilt = int'(filt_rd_addr);
      sPsum = int'(psum_done);
      sSpl  = int'(stride_pos_ld);
      if (rd_en) begin
         gotIf.push_back(int'(if_rd_addr));
         gotFilt.push_back(int'(filt_rd_addr));
      end
      psumCnt += int'(psum_done);
      scfCnt  += int'(stride_count_flag);
      splCnt  += int'(stride_pos_ld);
      fullCnt += int'(full_done);
      macCnt  += int'(mac_valid);
      @(posedge clk);
      #1;
   endtask

   task automatic compareSeq(input string tag, input int got[$], input int expv[$]);
      checkOutput({tag, ".len"}, got.size(), expv.size());
      for (int j = 0; j < expv.size() && j < got.size(); j++)
         checkOutput($sformatf("%s[%0d]", tag, j), got[j], expv[j]);
   endtask

   // mode: 0 plain, 1 IF starvation, 2 late clear, 3 reset_Filter abort
   task automatic applyStimulus(input bit usage, input int mode);
      int  delay;
      bit  aborted;
      bit  done;
      delay = 0; aborted = 1'b0; done = 1'b0;
      splAfter = -1; stallRd = -1;
      clearMon();
      if (mode == 1) if_avail = 6'd1;
      if (mode == 2) begin tieClr = 1'b0; clrManual = 1'b0; end
      usage_stride_pos_ld = usage;
      start_rd_gen = 1'b1;
      stepCycle();
      start_rd_gen = 1'b0;
      usage_stride_pos_ld = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (mode == 1) if_avail = (i < 5) ? 6'd1 : 6'd8;
         stepCycle();
         if (mode == 1 && i == 2) stallRd = sRd;
         if (mode == 2) begin
            if (clrManual) clrManual = 1'b0;
            if (sPsum != 0) delay = 4;
            else if (delay > 0) begin
               delay--;
               if (delay == 0) clrManual = 1'b1;
            end
         end
         if (mode == 3) begin
            if (reset_Filter) reset_Filter = 1'b0;
            else if (!aborted && sRd != 0 && sIf == 3 && sFilt == 1) begin
               reset_Filter = 1'b1;
               aborted = 1'b1;
            end
         end
         if (sSpl != 0) begin
            done = 1'b1;
            splAfter = i + 1;
         end
      end
      checkOutput("rowDone", int'(done), 1);
      tieClr = 1'b1;
      clrManual = 1'b0;
      reset_Filter = 1'b0;
   endtask

   initial begin
      basicIf    = '{0, 1, 2, 2, 3, 4, 4, 5, 6};
      basicFilt  = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
      abortIf    = '{0, 1, 2, 2, 3, 2, 3, 4, 4, 5, 6};
      abortFilt  = '{0, 1, 2, 0, 1, 0, 1, 2, 0, 1, 2};
      resumeIf   = '{6, 7, 8};
      resumeFilt = '{0, 1, 2};

      rst = 1'b0; reset_all = 1'b0; start_rd_gen = 1'b0; usage_stride_pos_ld = 1'b0;
      reset_Filter = 1'b0; tieClr = 1'b1; clrManual = 1'b0;
      filt_len = 4'd3; if_len = 6'd8; stride = 5'd2; if_avail = 6'd8;
      if_last = 1'b0; psum_ready = 1'b1;

      @(negedge clk);
      checkOutput("resetOutputs", outVec(), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      stepCycle();

      $display("[TB] basic row, if_last=0");
      applyStimulus(1'b0, 0);
      compareSeq("basicIf", gotIf, basicIf);
      compareSeq("basicFilt", gotFilt, basicFilt);
      checkOutput("basicPsum", psumCnt, 3);
      checkOutput("basicScf", scfCnt, 2);
      checkOutput("basicSpl", splCnt, 1);
      checkOutput("basicFull", fullCnt, 0);
      checkOutput("basicMac", macCnt, 9);

      $display("[TB] resume from saved position");
      if_avail = 6'd16;
      applyStimulus(1'b1, 0);
      compareSeq("resumeIf", gotIf, resumeIf);
      compareSeq("resumeFilt", gotFilt, resumeFilt);
      checkOutput("resumeScf", scfCnt, 0);
      if_avail = 6'd8;

      $display("[TB] fresh start with if_last=1");
      if_last = 1'b1;
      applyStimulus(1'b0, 0);
      compareSeq("lastIf", gotIf, basicIf);
      checkOutput("lastFull", fullCnt, 1);
      if_last = 1'b0;

      $display("[TB] IF starvation");
      applyStimulus(1'b0, 1);
      compareSeq("starveIf", gotIf, basicIf);
      compareSeq("starveFilt", gotFilt, basicFilt);
      checkOutput("starveStallRd", stallRd, 0);

      $display("[TB] late clear");
      applyStimulus(1'b0, 2);
      compareSeq("lateIf", gotIf, basicIf);
      checkOutput("latePsum", psumCnt, 3);
      checkOutput("lateScf", scfCnt, 2);

      $display("[TB] reset_Filter abort");
      applyStimulus(1'b0, 3);
      compareSeq("abortIf", gotIf, abortIf);
      compareSeq("abortFilt", gotFilt, abortFilt);
      checkOutput("abortScf", scfCnt, 2);
      checkOutput("abortPsum", psumCnt, 3);

      $display("[TB] degenerate row");
      filt_len = 4'd5; if_len = 6'd4;
      applyStimulus(1'b0, 0);
      checkOutput("degenRd", gotIf.size(), 0);
      checkOutput("degenSplAt", splAfter, 1);
      stepCycle();
      checkOutput("degenSplWidth", sSpl, 0);
      filt_len = 4'd3; if_len = 6'd8;

      $display("[TB] reset_all mid-row");
      clearMon();
      start_rd_gen = 1'b1;
      stepCycle();
      start_rd_gen = 1'b0;
      stepCycle();
      stepCycle();
      reset_all = 1'b1;
      stepCycle();
      checkOutput("softClrRd", sRd, 0);
      reset_all = 1'b0;
      clearMon();
      for (int i = 0; i < 3; i++) stepCycle();
      checkOutput("softClrIdle", gotIf.size(), 0);
      applyStimulus(1'b1, 0);
      checkOutput("softClrSpCleared", (gotIf.size() > 0) ? gotIf[0] : -1, 0);

      $display("[TB] async reset mid-row");
      start_rd_gen = 1'b1;
      stepCycle();
      start_rd_gen = 1'b0;
      stepCycle();
      rst = 1'b0;
      #1;
      checkOutput("asyncRstOutputs", outVec(), 0);
      #1;
      rst = 1'b1;
      clearMon();
      for (int i = 0; i < 3; i++) stepCycle();
      checkOutput("asyncRstIdle", gotIf.size(), 0);
      checkOutput("asyncRstMac", macCnt, 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
